wb_initiator: RTL and testbench
===============================

// Module: wb_initiator
//
// PURPOSE
//   Wishbone classic initiator (bus master). It turns a valid/ready command stream from the vector
//   coprocessor control logic into single Wishbone read/write cycles and returns one response per request.
//   It is the master-side counterpart to the Wishbone slave port of the user project.
//   Typical uses: fetching vector operands from, and writing results to, Wishbone-mapped memories.
//
// PARAMETERS
//   AW              32   address width, in bits
//   DW              32   data width, in bits; the select width is DW/8
//   TIMEOUT_CYCLES  16   cycles to wait for an ack before aborting (WBM_TIMEOUT_EN only); must be >=1
//
// PORTS
//   clk          in   1      single clock for all logic
//   reset_n      in   1      synchronous, active-low reset
//   req_valid    in   1      a command is present
//   req_ready    out  1      the block can accept a command
//   req_we       in   1      1 = write, 0 = read
//   req_adr      in   AW     byte address
//   req_dat      in   DW     write data
//   req_sel      in   DW/8   byte selects
//   resp_valid   out  1      a response is present
//   resp_ready   in   1      the consumer takes the response
//   resp_dat     out  DW     read data; 0 for writes
//   resp_err     out  1      1 = transaction aborted by timeout
//   wbm_cyc_o    out  1      Wishbone CYC
//   wbm_stb_o    out  1      Wishbone STB
//   wbm_we_o     out  1      Wishbone WE
//   wbm_sel_o    out  DW/8   Wishbone SEL
//   wbm_adr_o    out  AW     Wishbone ADR
//   wbm_dat_o    out  DW     Wishbone write data
//   wbm_ack_i    in   1      Wishbone ACK
//   wbm_dat_i    in   DW     Wishbone read data
//
// BEHAVIOUR
//   - Reset (reset_n=0 at a clk edge) forces state IDLE.
//     All outputs are 0, except req_ready, which is 1 once the block is in IDLE.
//   - FSM states: IDLE -> BUS -> RESP -> IDLE.
//   - IDLE
//     - req_ready=1.
//     - On req_valid&&req_ready: latch we/adr/dat/sel and go to BUS.
//   - BUS
//     - cyc=stb=1 from the cycle after acceptance; adr/dat/sel/we are held stable.
//     - req_ready=0.
//     - On wbm_ack_i: capture resp_dat (wbm_dat_i for reads, 0 for writes), set resp_err=0, go to RESP.
//       cyc and stb drop on the next edge.
//   - RESP
//     - resp_valid=1; resp_dat and resp_err are held stable.
//     - On resp_ready: go to IDLE.
//   - Latency with a zero-wait slave (ack in the first STB cycle):
//     - accept at edge 0, STB high during cycle 1, resp_valid high during cycle 2;
//     - next accept possible at edge 3 if resp_ready=1 during cycle 2.
//   - wbm_ack_i is ignored outside BUS.
//   - wbm_dat_o/adr/sel/we hold their last values when idle; this is not a requirement.
//   - Only one transaction is ever outstanding; there is no pipelining and no burst (CTI/BTE absent).
//   - Reset in BUS or RESP: cyc/stb/resp_valid are 0 after that edge and the pending response is discarded.
//
// CONFIGURATION
//   - WBM_TIMEOUT_EN defined:
//     - A counter clears on entry to BUS and increments each BUS cycle without an ack.
//     - On the BUS cycle where it reaches TIMEOUT_CYCLES with no ack:
//       drop cyc/stb, set resp_err=1 and resp_dat=32'hDEAD_BEEF, go to RESP.
//     - If ack and the timeout occur in the same cycle, the ack wins and resp_err=0.
//   - WBM_TIMEOUT_EN undefined:
//     - BUS waits for the ack indefinitely.
//     - resp_err is tied to 0 and the counter is not instantiated.
//
// STRUCTURE
//   - Package wbm_pkg holds:
//     - typedef enum logic [1:0] {IDLE, BUS, RESP} wbm_state_t;
//     - localparam WBM_ERR_DATA = 32'hDEAD_BEEF;
//     - a request struct with fields we/adr/dat/sel.
//   - One sub-module, wbm_timeout_ctr, instantiated only under WBM_TIMEOUT_EN. Its ports are:
//     - clk, reset_n, clear, enable, expired.
//
// TESTING
//   1. Write to adr 0x3000_0004, dat 0xCAFE_F00D, sel 0xF; slave acks on the 3rd STB cycle
//      -> cyc/stb high for exactly 3 cycles; wbm_dat_o=0xCAFE_F00D; resp_valid with resp_dat=0 and resp_err=0.
//   2. Read from 0x3000_0010; slave acks in the 1st STB cycle with 0x1234_5678
//      -> resp_valid 2 cycles after accept; resp_dat=0x1234_5678.
//   3. Read completes while resp_ready is held 0 for 5 cycles
//      -> resp_valid and resp_dat stay stable; req_ready=0 throughout; IDLE on the cycle after resp_ready=1.
//   4. WBM_TIMEOUT_EN with TIMEOUT_CYCLES=16 and a slave that never acks
//      -> cyc drops after 16 STB cycles; resp_err=1; resp_dat=0xDEAD_BEEF.
//   5. WBM_TIMEOUT_EN with the ack arriving in the 16th STB cycle
//      -> resp_err=0 and resp_dat equals the slave's data.
//   6. reset_n pulsed low for 1 cycle during BUS
//      -> cyc/stb=0 and resp_valid=0 on the next cycle; a late ack is ignored; req_ready=1.

Source files
------------

// File: rtl/wbm_pkg.sv
// Shared types and constants for the Wishbone classic initiator.
// The request struct is sized by WBM_AW/WBM_DW, so those must cover the initiator's AW/DW.
package wbm_pkg;

  localparam int WBM_AW = 32;
  localparam int WBM_DW = 32;
  localparam int WBM_SW = WBM_DW / 8;

  localparam logic [31:0] WBM_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_t;

  typedef struct packed {
    logic              we;
    logic [WBM_AW-1:0] adr;
    logic [WBM_DW-1:0] dat;
    logic [WBM_SW-1:0] sel;
  } wbm_req_t;

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Counts BUS cycles without an ack; expired is high during the LIMIT-th such cycle.
// Only instantiated by wb_initiator when WBM_TIMEOUT_EN is defined.
module wbm_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Count is 0 in the first BUS cycle, so the LIMIT-th cycle sees LIMIT-1.
  assign expired = (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one valid/ready command becomes one single read/write cycle.
// Optional ack timeout enabled by defining WBM_TIMEOUT_EN.
module wb_initiator
  import wbm_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_adr,
  input  logic [DW-1:0]   req_dat,
  input  logic [DW/8-1:0] req_sel,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [DW-1:0]   resp_dat,
  output logic            resp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
    $error("wb_initiator: TIMEOUT_CYCLES must be >= 1");
  end

  wbm_state_t    r_state;
  wbm_req_t      r_req;
  logic          r_reqReady;
  logic          r_cycStb;
  logic          r_respValid;
  logic [DW-1:0] r_respDat;
  logic          w_accept;
  logic          w_expired;

  assign w_accept = r_reqReady && req_valid;

`ifdef WBM_TIMEOUT_EN
  logic r_respErr;
  logic w_ctrEnable;

  assign w_ctrEnable = (r_state == BUS) && !wbm_ack_i;

  wbm_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (w_accept),
    .enable (w_ctrEnable),
    .expired(w_expired)
  );

  assign resp_err = r_respErr;
`else
  assign w_expired = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // Single-outstanding FSM; every output is a register so the bus sees clean edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_reqReady  <= 1'b1;
      r_cycStb    <= 1'b0;
      r_respValid <= 1'b0;
      r_respDat   <= '0;
`ifdef WBM_TIMEOUT_EN
      r_respErr   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req.we    <= req_we;
            r_req.adr   <= WBM_AW'(req_adr);
            r_req.dat   <= WBM_DW'(req_dat);
            r_req.sel   <= WBM_SW'(req_sel);
            r_reqReady  <= 1'b0;
            r_cycStb    <= 1'b1;
            r_state     <= BUS;
          end
        end
        BUS: begin
          // An ack in the timeout cycle still completes the transfer normally.
          if (wbm_ack_i) begin
            r_respDat   <= r_req.we ? '0 : wbm_dat_i;
            r_cycStb    <= 1'b0;
            r_respValid <= 1'b1;
            r_state     <= RESP;
`ifdef WBM_TIMEOUT_EN
            r_respErr   <= 1'b0;
          end else if (w_expired) begin
            r_respDat   <= DW'(WBM_ERR_DATA);
            r_respErr   <= 1'b1;
            r_cycStb    <= 1'b0;
            r_respValid <= 1'b1;
            r_state     <= RESP;
`endif
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_respValid <= 1'b0;
            r_reqReady  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_cycStb    <= 1'b0;
          r_respValid <= 1'b0;
          r_reqReady  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`ifndef WBM_TIMEOUT_EN
  logic w_unusedExpired;
  assign w_unusedExpired = w_expired;
`endif

  assign req_ready  = r_reqReady;
  assign resp_valid = r_respValid;
  assign resp_dat   = r_respDat;
  assign wbm_cyc_o  = r_cycStb;
  assign wbm_stb_o  = r_cycStb;
  assign wbm_we_o   = r_req.we;
  assign wbm_adr_o  = AW'(r_req.adr);
  assign wbm_dat_o  = DW'(r_req.dat);
  assign wbm_sel_o  = (DW/8)'(r_req.sel);

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: vector table + response scoreboard, plus reset-in-BUS sequence.
// Timeout vectors are only added when WBM_TIMEOUT_EN is defined.
module tb_wb_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;
  logic [3:0]    req_sel;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_dat;
  logic          resp_err;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic          wbm_ack_i;
  logic [DW-1:0] wbm_dat_i;

  always #5 clk = ~clk;

  wb_initiator #(
    .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_dat(resp_dat), .resp_err(resp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  // ackAt = STB cycle in which the slave acks; 0 means it never acks.
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ackAt;
    logic [31:0] ackDat;
    int          stall;
    logic [31:0] expDat;
    logic        expErr;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  function automatic vec_t mkVec(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input int ackAt, input logic [31:0] ackDat,
                                 input int stall, input logic [31:0] expDat, input logic expErr);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.ackAt = ackAt;
    v.ackDat = ackDat; v.stall = stall; v.expDat = expDat; v.expErr = expErr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic popCompare();
    exp_t e;
    if (sb.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL sb_empty: got response %0h, expected none", resp_dat);
    end else begin
      e = sb.pop_front();
      checkOutput("resp_dat", resp_dat, e.dat);
      checkOutput("resp_err", resp_err, e.err);
    end
  endtask

  // Called and returns at a negedge; the DUT must be idle on entry.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   stbCycles;
    int   expCycles;
    checkOutput("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_adr   = v.adr;
    req_dat   = v.dat;
    req_sel   = v.sel;
    e.dat = v.expDat;
    e.err = v.expErr;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_dat   = 32'h0;
    req_adr   = 32'h0;
    stbCycles = 0;
    while (wbm_stb_o && stbCycles < 100) begin
      stbCycles++;
      checkOutput("bus_cyc", wbm_cyc_o, 1);
      checkOutput("bus_we", wbm_we_o, v.we);
      checkOutput("bus_adr", wbm_adr_o, v.adr);
      checkOutput("bus_dat", wbm_dat_o, v.dat);
      checkOutput("bus_sel", wbm_sel_o, v.sel);
      checkOutput("bus_req_ready", req_ready, 0);
      wbm_ack_i = (stbCycles == v.ackAt);
      wbm_dat_i = (stbCycles == v.ackAt) ? v.ackDat : $urandom;
      @(negedge clk);
    end
    wbm_ack_i = 1'b0;
    expCycles = (v.ackAt == 0) ? TO : v.ackAt;
    checkOutput("stb_cycles", 64'(stbCycles), 64'(expCycles));
    checkOutput("resp_valid", resp_valid, 1);
    checkOutput("resp_cyc_low", wbm_cyc_o, 0);
    for (int i = 0; i < v.stall; i++) begin
      checkOutput("stall_resp_valid", resp_valid, 1);
      checkOutput("stall_req_ready", req_ready, 0);
      checkOutput("stall_resp_dat", resp_dat, v.expDat);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    if (resp_valid) popCompare();
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("post_resp_valid", resp_valid, 0);
    checkOutput("post_req_ready", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_adr    = '0;
    req_dat    = '0;
    req_sel    = '0;
    resp_ready = 1'b0;
    wbm_ack_i  = 1'b0;
    wbm_dat_i  = '0;
    repeat (3) @(negedge clk);

    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_cyc", wbm_cyc_o, 0);
    checkOutput("rst_stb", wbm_stb_o, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_dat", resp_dat, 0);
    checkOutput("rst_resp_err", resp_err, 0);
    checkOutput("rst_adr", wbm_adr_o, 0);
    checkOutput("rst_dat", wbm_dat_o, 0);
    checkOutput("rst_sel", wbm_sel_o, 0);
    checkOutput("rst_we", wbm_we_o, 0);
    reset_n = 1'b1;

    // A stray ack while idle must not start or complete anything.
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h5555_AAAA;
    repeat (2) @(negedge clk);
    wbm_ack_i = 1'b0;
    checkOutput("idle_ack_cyc", wbm_cyc_o, 0);
    checkOutput("idle_ack_resp_valid", resp_valid, 0);
    checkOutput("idle_ack_req_ready", req_ready, 1);

    vecs.push_back(mkVec(1'b1, 32'h3000_0004, 32'hCAFE_F00D, 4'hF, 3, 32'hFFFF_FFFF, 0, 32'h0, 1'b0));
    vecs.push_back(mkVec(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 32'h1234_5678, 0, 32'h1234_5678, 1'b0));
    vecs.push_back(mkVec(1'b0, 32'h3000_0020, 32'h0, 4'hF, 2, 32'hA5A5_0F0F, 5, 32'hA5A5_0F0F, 1'b0));
    vecs.push_back(mkVec(1'b1, 32'h3000_0100, 32'h0000_00FF, 4'h1, 1, 32'h1111_2222, 1, 32'h0, 1'b0));
    vecs.push_back(mkVec(1'b0, 32'h3000_0FFC, 32'h7777_7777, 4'hC, 4, 32'h8000_0001, 0, 32'h8000_0001, 1'b0));
`ifdef WBM_TIMEOUT_EN
    vecs.push_back(mkVec(1'b0, 32'h3000_0200, 32'h0, 4'hF, 0, 32'h0, 0, 32'hDEAD_BEEF, 1'b1));
    vecs.push_back(mkVec(1'b0, 32'h3000_0204, 32'h0, 4'hF, TO, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0));
    vecs.push_back(mkVec(1'b1, 32'h3000_0208, 32'h0123_4567, 4'h3, 0, 32'h0, 2, 32'hDEAD_BEEF, 1'b1));
`endif

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset pulse in the middle of a BUS phase discards the transaction.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_adr   = 32'h3000_0040;
    req_sel   = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rstbus_cyc_before", wbm_cyc_o, 1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("rstbus_cyc", wbm_cyc_o, 0);
    checkOutput("rstbus_stb", wbm_stb_o, 0);
    checkOutput("rstbus_resp_valid", resp_valid, 0);
    checkOutput("rstbus_req_ready", req_ready, 1);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h9999_9999;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    checkOutput("late_ack_resp_valid", resp_valid, 0);
    checkOutput("late_ack_cyc", wbm_cyc_o, 0);
    checkOutput("late_ack_req_ready", req_ready, 1);

    applyStimulus(mkVec(1'b0, 32'h3000_0044, 32'h0, 4'hF, 2, 32'h4242_4242, 0, 32'h4242_4242, 1'b0));

    checkOutput("sb_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
